// File: rtl/ysyx_24090012_lsu.sv
// rtl/ysyx_24090012_lsu.sv - load/store unit between EXU and WBU with an AXI4-Lite master port
module ysyx_24090012_lsu #(
  parameter int ADDR_W            = 32,
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [31:0]       exu_inst,
  input  logic [31:0]       exu_rd_data,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              wbu_valid,
  input  logic              wbu_ready,
  output logic [31:0]       wbu_inst,
  output logic [31:0]       wbu_rd_data,
  output logic              wbu_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_A  = 3'd1;
  localparam logic [2:0] S_RD_D  = 3'd2;
  localparam logic [2:0] S_WR_AW = 3'd3;
  localparam logic [2:0] S_WR_B  = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic [31:0]       inst_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_done, w_done;
  logic [31:0]       res_data;
  logic              res_fault;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, misaligned, fault_acc;
  logic [1:0]  off_in;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in;
  logic [31:0] word;
  logic [31:0] load_ext;

  assign opcode = exu_inst[6:0];
  assign funct3 = exu_inst[14:12];

  // Decode the incoming instruction and precompute the store lanes at accept time
  always_comb begin
    is_load    = (opcode == 7'b0000011) &&
                 (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_store   = (opcode == 7'b0100011) && (funct3 inside {3'b000, 3'b001, 3'b010});
    misaligned = (is_load || is_store) &&
                 (((funct3[1:0] == 2'b01) && mem_addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)));
    fault_acc  = FAULT_ON_MISALIGN && misaligned;
    // Without faulting, a misaligned access degrades to the aligned word
    off_in     = misaligned ? 2'b00 : mem_addr[1:0];
    case (funct3[1:0])
      2'b00:   begin wstrb_in = 4'b0001 << off_in; wdata_in = {4{mem_wdata[7:0]}};  end
      2'b01:   begin wstrb_in = 4'b0011 << off_in; wdata_in = {2{mem_wdata[15:0]}}; end
      default: begin wstrb_in = 4'hF;              wdata_in = mem_wdata;            end
    endcase
  end

  // Shift the read beat down to the addressed lane and extend to 32 bits
  always_comb begin
    word = rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{word[7]}}, word[7:0]};
      3'b100:  load_ext = {24'h0, word[7:0]};
      3'b001:  load_ext = {{16{word[15]}}, word[15:0]};
      3'b101:  load_ext = {16'h0, word[15:0]};
      default: load_ext = word;
    endcase
  end

  // Next-state selection for the access sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mem_valid) begin
        if (fault_acc)     state_nxt = S_WB;
        else if (is_load)  state_nxt = S_RD_A;
        else if (is_store) state_nxt = S_WR_AW;
        else               state_nxt = S_WB;
      end
      S_RD_A:  if (arready) state_nxt = S_RD_D;
      S_RD_D:  if (rvalid)  state_nxt = S_WB;
      S_WR_AW: if ((aw_done || awready) && (w_done || wready)) state_nxt = S_WR_B;
      S_WR_B:  if (bvalid)  state_nxt = S_WB;
      S_WB:    if (wbu_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus the request/result holding registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      off_q     <= 2'b00;
      funct3_q  <= 3'b000;
      inst_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      res_data  <= 32'h0;
      res_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (mem_valid) begin
          addr_q    <= {mem_addr[ADDR_W-1:2], 2'b00};
          off_q     <= off_in;
          funct3_q  <= funct3;
          inst_q    <= exu_inst;
          wdata_q   <= wdata_in;
          wstrb_q   <= wstrb_in;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          res_data  <= fault_acc ? 32'h0 : exu_rd_data;
          res_fault <= fault_acc;
        end
        S_RD_D: if (rvalid) begin
          res_data  <= (rresp != 2'b00) ? 32'h0 : load_ext;
          res_fault <= (rresp != 2'b00);
        end
        S_WR_AW: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
        end
        S_WR_B: if (bvalid) res_fault <= (bresp != 2'b00);
        default: ;
      endcase
    end
  end

  assign mem_ready   = (state == S_IDLE);
  assign arvalid     = (state == S_RD_A);
  assign rready      = (state == S_RD_D);
  assign awvalid     = (state == S_WR_AW) && !aw_done;
  assign wvalid      = (state == S_WR_AW) && !w_done;
  assign bready      = (state == S_WR_B);
  assign wbu_valid   = (state == S_WB);
  assign araddr      = addr_q;
  assign awaddr      = addr_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign wbu_inst    = inst_q;
  assign wbu_rd_data = res_data;
  assign wbu_fault   = res_fault;

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// tb/tb_ysyx_24090012_lsu.sv - directed self-checking bench for ysyx_24090012_lsu
module tb_ysyx_24090012_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, exu_inst, exu_rd_data;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        wbu_valid, wbu_ready;
  logic [31:0] wbu_inst, wbu_rd_data;
  logic        wbu_fault;

  int tests = 0;
  int fails = 0;

  ysyx_24090012_lsu dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .exu_inst(exu_inst), .exu_rd_data(exu_rd_data),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wbu_valid(wbu_valid), .wbu_ready(wbu_ready), .wbu_inst(wbu_inst),
    .wbu_rd_data(wbu_rd_data), .wbu_fault(wbu_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for a single clock edge; returns at the negedge after acceptance
  task automatic issue(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd);
    mem_valid = 1'b1; exu_inst = inst; mem_addr = addr; mem_wdata = wd; exu_rd_data = rd;
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] rd_beat, input logic [1:0] resp,
                         input logic [31:0] exp_araddr, input logic [31:0] exp_data,
                         input logic exp_fault);
    issue(inst, addr, 32'h0, 32'h0BAD0BAD);
    chk({tag, " arvalid"}, {31'h0, arvalid}, 32'h1);
    chk({tag, " araddr"}, araddr, exp_araddr);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk({tag, " rready"}, {31'h0, rready}, 32'h1);
    rvalid = 1'b1; rdata = rd_beat; rresp = resp;
    @(negedge clk);
    rvalid = 1'b0;
    chk({tag, " wbu_valid"}, {31'h0, wbu_valid}, 32'h1);
    chk({tag, " rd_data"}, wbu_rd_data, exp_data);
    chk({tag, " fault"}, {31'h0, wbu_fault}, {31'h0, exp_fault});
    @(negedge clk);
    chk({tag, " back to idle"}, {31'h0, mem_ready}, 32'h1);
  endtask

  task automatic do_store(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] resp,
                          input logic [31:0] exp_awaddr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic exp_fault);
    issue(inst, addr, wd, 32'h0);
    chk({tag, " aw/w valid"}, {30'h0, awvalid, wvalid}, 32'h3);
    chk({tag, " awaddr"}, awaddr, exp_awaddr);
    chk({tag, " wstrb"}, {28'h0, wstrb}, {28'h0, exp_strb});
    chk({tag, " wdata"}, wdata, exp_wdata);
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk({tag, " bready"}, {31'h0, bready}, 32'h1);
    bvalid = 1'b1; bresp = resp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    chk({tag, " wbu_valid"}, {31'h0, wbu_valid}, 32'h1);
    chk({tag, " fault"}, {31'h0, wbu_fault}, {31'h0, exp_fault});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    exu_inst = 32'h0; exu_rd_data = 32'h0; arready = 1'b0; rdata = 32'h0;
    rresp = 2'b00; rvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    bresp = 2'b00; bvalid = 1'b0; wbu_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset mem_ready", {31'h0, mem_ready}, 32'h1);
    chk("reset valids", {25'h0, arvalid, rready, awvalid, wvalid, bready, wbu_valid, wbu_fault}, 32'h0);
    chk("reset araddr", araddr, 32'h0);
    chk("reset wstrb", {28'h0, wstrb}, 32'h0);
    chk("reset rd_data", wbu_rd_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // ADDI: one cycle to WB, no bus activity
    issue(32'h00500093, 32'h80000000, 32'h0, 32'h00000055);
    chk("addi wbu_valid", {31'h0, wbu_valid}, 32'h1);
    chk("addi rd_data", wbu_rd_data, 32'h00000055);
    chk("addi inst", wbu_inst, 32'h00500093);
    chk("addi no bus", {30'h0, arvalid, awvalid}, 32'h0);
    @(negedge clk);
    chk("addi idle", {30'h0, mem_ready, wbu_valid}, 32'h2);

    do_load("lb",  32'h00010083, 32'h80000003, 32'h80FFFFFF, 2'b00, 32'h80000000, 32'hFFFFFF80, 1'b0);
    do_load("lbu", 32'h00014083, 32'h80000003, 32'h80FFFFFF, 2'b00, 32'h80000000, 32'h00000080, 1'b0);
    do_load("lh",  32'h00011083, 32'h80000002, 32'h80011234, 2'b00, 32'h80000000, 32'hFFFF8001, 1'b0);
    do_load("lhu", 32'h00015083, 32'h80000002, 32'h80011234, 2'b00, 32'h80000000, 32'h00008001, 1'b0);
    do_load("lw rerr", 32'h00012083, 32'h80000008, 32'h12345678, 2'b10, 32'h80000008, 32'h0, 1'b1);

    do_store("sh", 32'h00209023, 32'h80000002, 32'h1234ABCD, 2'b00, 32'h80000000, 4'b1100, 32'hABCDABCD, 1'b0);
    do_store("sb", 32'h00208023, 32'h80000001, 32'h000000A5, 2'b00, 32'h80000000, 4'b0010, 32'hA5A5A5A5, 1'b0);
    do_store("sw berr", 32'h0020A023, 32'h80000010, 32'h11223344, 2'b10, 32'h80000010, 4'hF, 32'h11223344, 1'b1);

    // SW with wready three cycles after awready
    issue(32'h0020A023, 32'h80000010, 32'hDEADBEEF, 32'h0);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk("sw split aw done", {29'h0, awvalid, wvalid, bready}, 32'h2);
    @(negedge clk);
    chk("sw split waiting", {29'h0, awvalid, wvalid, bready}, 32'h2);
    @(negedge clk);
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    chk("sw split bready", {29'h0, awvalid, wvalid, bready}, 32'h1);
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    chk("sw split wb", {30'h0, wbu_valid, wbu_fault}, 32'h2);
    @(negedge clk);
    chk("sw split one beat", {31'h0, wbu_valid}, 32'h0);

    // Misaligned LW: no bus access, fault with zero data
    issue(32'h00012083, 32'h80000001, 32'h0, 32'h00000077);
    chk("lw misalign arvalid", {31'h0, arvalid}, 32'h0);
    chk("lw misalign wb", {30'h0, wbu_valid, wbu_fault}, 32'h3);
    chk("lw misalign data", wbu_rd_data, 32'h0);
    @(negedge clk);

    // Undefined funct3 on load opcode forwards EXU result
    issue(32'h00013083, 32'h80000000, 32'h0, 32'h00000099);
    chk("bad funct3 wb", {29'h0, wbu_valid, wbu_fault, arvalid}, 32'h4);
    chk("bad funct3 data", wbu_rd_data, 32'h00000099);
    @(negedge clk);

    // WBU back-pressure: outputs hold, nothing new captured
    wbu_ready = 1'b0;
    issue(32'h00500093, 32'h80000000, 32'h0, 32'h00000055);
    mem_valid = 1'b1; exu_inst = 32'h00A00113; exu_rd_data = 32'h000000AA;
    for (int i = 0; i < 5; i++) begin
      chk("stall valid/ready", {30'h0, wbu_valid, mem_ready}, 32'h2);
      chk("stall rd_data", wbu_rd_data, 32'h00000055);
      chk("stall inst", wbu_inst, 32'h00500093);
      @(negedge clk);
    end
    mem_valid = 1'b0; wbu_ready = 1'b1;
    @(negedge clk);
    chk("stall release", {30'h0, wbu_valid, mem_ready}, 32'h1);

    // Reset asserted while waiting for read data
    issue(32'h00012083, 32'h80000004, 32'h0, 32'h0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("rst pre rready", {31'h0, rready}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rst async drop", {29'h0, arvalid, rready, mem_ready}, 32'h1);
    rvalid = 1'b1; rdata = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    chk("rst late resp ignored", {30'h0, wbu_valid, mem_ready}, 32'h1);
    chk("rst data cleared", wbu_rd_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
